// File: rtl/timer0_prescaler_if.sv
// rtl/timer0_prescaler_if.sv - signal bundle between the register file and the Timer0 prescaler
//
// Ports carried:
//   TCCR_data[7:0]      TCCR0 contents, only CS02:CS00 = [2:0] are used
//   PSR_clear           prescaler-reset request (PSR10), level-sensitive
//   T0_pin              external clock pin, asynchronous
//   countClock          one-cycle count-enable pulse to the timer control unit
//   PSR_done            one-cycle pulse asking the register file to clear PSR10
//   prescale_count[9:0] live prescaler counter value (debug)
// master = register file / stimulus side, slave = prescaler.
interface timer0_prescaler_if;
  logic [7:0] TCCR_data;
  logic       PSR_clear;
  logic       T0_pin;
  logic       countClock;
  logic       PSR_done;
  logic [9:0] prescale_count;

  modport master (
    output TCCR_data, PSR_clear, T0_pin,
    input  countClock, PSR_done, prescale_count
  );

  modport slave (
    input  TCCR_data, PSR_clear, T0_pin,
    output countClock, PSR_done, prescale_count
  );
endinterface

// File: rtl/timer0_prescaler.sv
// rtl/timer0_prescaler.sv - Timer0 clock prescaler and count-enable select
//
// Free-running 10-bit prescaler; CS02:CS00 picks which counter phase (or which
// T0 edge) produces a registered one-cycle countClock pulse.
//
// Ports:
//   sysClock  system clock, all flops on rising edge
//   reset_n   synchronous active-low reset
//   bus       timer0_prescaler_if.slave (TCCR_data, PSR_clear, T0_pin in;
//             countClock, PSR_done, prescale_count out)
//
// Build option: TIMER0_EXT_CLK_EN
//   defined     CS=110/111 count on falling/rising T0 edges (2-flop sync + edge flop)
//   undefined   T0 logic not built, T0_pin unused, CS=110/111 act as stopped
module timer0_prescaler (
  input  logic                 sysClock,
  input  logic                 reset_n,
  timer0_prescaler_if.slave    bus
);

  logic [2:0] cs;
  logic       sel;

  logic [9:0] cnt_q, cnt_d;
  logic       cc_q, cc_d;
  logic       done_q, done_d;
  logic       psr_prev_q;

  assign cs = bus.TCCR_data[2:0];

`ifdef TIMER0_EXT_CLK_EN
  logic t0_s1_q, t0_s2_q, t0_prev_q;
  logic t0_rise, t0_fall;

  // Synchroniser and edge flop run regardless of CS so a CS switch to an
  // external mode never sees a stale edge.
  always_ff @(posedge sysClock) begin
    if (!reset_n) begin
      t0_s1_q   <= 1'b0;
      t0_s2_q   <= 1'b0;
      t0_prev_q <= 1'b0;
    end else begin
      t0_s1_q   <= bus.T0_pin;
      t0_s2_q   <= t0_s1_q;
      t0_prev_q <= t0_s2_q;
    end
  end

  assign t0_rise = t0_s2_q & ~t0_prev_q;
  assign t0_fall = ~t0_s2_q & t0_prev_q;

  logic unused_tccr;
  assign unused_tccr = &{1'b0, bus.TCCR_data[7:3]};
`else
  logic unused_inputs;
  assign unused_inputs = &{1'b0, bus.T0_pin, bus.TCCR_data[7:3]};
`endif

  // Each divided mode fires in the cycle where the low bits of the counter
  // are all ones, i.e. once per 2^n cycles.
  always_comb begin
    sel = 1'b0;
    case (cs)
      3'b001:  sel = 1'b1;
      3'b010:  sel = &cnt_q[2:0];
      3'b011:  sel = &cnt_q[5:0];
      3'b100:  sel = &cnt_q[7:0];
      3'b101:  sel = &cnt_q[9:0];
`ifdef TIMER0_EXT_CLK_EN
      3'b110:  sel = t0_fall;
      3'b111:  sel = t0_rise;
`endif
      default: sel = 1'b0;
    endcase
  end

  always_comb begin
    cnt_d  = bus.PSR_clear ? 10'd0 : cnt_q + 10'd1;
    // A prescaler clear also kills the pulse that would have followed.
    cc_d   = sel & ~bus.PSR_clear;
    // Only the first sampled cycle of a held request acknowledges it.
    done_d = bus.PSR_clear & ~psr_prev_q;
  end

  always_ff @(posedge sysClock) begin
    if (!reset_n) begin
      cnt_q      <= 10'd0;
      cc_q       <= 1'b0;
      done_q     <= 1'b0;
      psr_prev_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      cc_q       <= cc_d;
      done_q     <= done_d;
      psr_prev_q <= bus.PSR_clear;
    end
  end

  assign bus.countClock     = cc_q;
  assign bus.PSR_done       = done_q;
  assign bus.prescale_count = cnt_q;

endmodule

// File: tb/tb_timer0_prescaler.sv
// tb/tb_timer0_prescaler.sv - self-checking bench for timer0_prescaler
module tb_timer0_prescaler;

  logic sysClock = 1'b0;
  logic reset_n;

  timer0_prescaler_if bus ();

  timer0_prescaler dut (
    .sysClock (sysClock),
    .reset_n  (reset_n),
    .bus      (bus)
  );

  always #5 sysClock = ~sysClock;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    logic [9:0] cnt;
    logic       cc;
    logic       done;
  } exp_t;

  exp_t sb_q[$];

  int   m_cnt = 0;
  bit   m_cc, m_done, m_psr_prev, m_s1, m_s2, m_prev;

  always @(posedge sysClock) begin : model
    int       period;
    bit       sel;
    logic [2:0] cs;
    exp_t     e;
    if (!reset_n) begin
      m_cnt = 0; m_cc = 0; m_done = 0; m_psr_prev = 0;
      m_s1 = 0; m_s2 = 0; m_prev = 0;
    end else begin
      cs = bus.TCCR_data[2:0];
      case (cs)
        3'd1:    period = 1;
        3'd2:    period = 8;
        3'd3:    period = 64;
        3'd4:    period = 256;
        3'd5:    period = 1024;
        default: period = 0;
      endcase
      sel = (period != 0) && ((m_cnt % period) == period - 1);
`ifdef TIMER0_EXT_CLK_EN
      if (cs == 3'd6) sel = (m_s2 == 0) && (m_prev == 1);
      if (cs == 3'd7) sel = (m_s2 == 1) && (m_prev == 0);
      m_prev = m_s2;
      m_s2   = m_s1;
      m_s1   = bus.T0_pin;
`endif
      m_cc       = sel && !bus.PSR_clear;
      m_done     = bus.PSR_clear && !m_psr_prev;
      m_psr_prev = bus.PSR_clear;
      m_cnt      = bus.PSR_clear ? 0 : (m_cnt + 1) % 1024;
    end
    e.cnt  = 10'(m_cnt);
    e.cc   = m_cc;
    e.done = m_done;
    sb_q.push_back(e);
  end

  always @(negedge sysClock) begin : scoreboard
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check("sb_count",     32'(bus.prescale_count), 32'(e.cnt));
      check("sb_countClock", 32'(bus.countClock),    32'(e.cc));
      check("sb_PSR_done",   32'(bus.PSR_done),      32'(e.done));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge sysClock);
    #1;
  endtask

  // Leaves the bench just after the last reset edge; the next tick is the
  // first edge sampled with reset_n high (counter becomes 1 there).
  task automatic do_reset(input logic [7:0] tccr);
    reset_n       = 1'b0;
    bus.PSR_clear = 1'b0;
    bus.T0_pin    = 1'b0;
    bus.TCCR_data = tccr;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic run_count(input int n, input int t0_period,
                           output int pulses, output int first, output int last);
    pulses = 0; first = 0; last = 0;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (bus.countClock === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
        last = k;
      end
      if (t0_period != 0 && (k % t0_period) == 0) bus.T0_pin = ~bus.T0_pin;
    end
  endtask

  typedef struct {
    logic [7:0] tccr;
    int         cycles;
    int         t0_period;
    int         pulses;
    int         first;
    int         last;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int p, f, l, dn;

    reset_n       = 1'b0;
    bus.TCCR_data = 8'h00;
    bus.PSR_clear = 1'b0;
    bus.T0_pin    = 1'b0;

    // tccr, cycles, t0 toggle period, pulses, first pulse edge, last pulse edge
    vecs[0] = '{8'h01,   20, 0,   20,    1,   20};
    vecs[1] = '{8'hF9,   20, 0,   20,    1,   20};  // upper TCCR bits ignored
    vecs[2] = '{8'h02,   40, 0,    5,    8,   40};
    vecs[3] = '{8'h03,  130, 0,    2,   64,  128};
    vecs[4] = '{8'h04,  600, 0,    2,  256,  512};
    vecs[5] = '{8'h05, 2100, 0,    2, 1024, 2048};
    vecs[6] = '{8'h00,  300, 0,    0,    0,    0};
`ifdef TIMER0_EXT_CLK_EN
    // T0 rises after edges 5,15,..,55 and falls after 10,20,..; 3-edge latency
    vecs[7] = '{8'h07,   60, 5,    6,    8,   58};
    vecs[8] = '{8'h06,   60, 5,    5,   13,   53};
`else
    vecs[7] = '{8'h07,   60, 5,    0,    0,    0};
    vecs[8] = '{8'h06,   60, 5,    0,    0,    0};
`endif

    // reset state
    do_reset(8'h01);
    check("reset_count",      32'(bus.prescale_count), 32'd0);
    check("reset_countClock", 32'(bus.countClock),     32'd0);
    check("reset_PSR_done",   32'(bus.PSR_done),       32'd0);

    foreach (vecs[i]) begin
      do_reset(vecs[i].tccr);
      run_count(vecs[i].cycles, vecs[i].t0_period, p, f, l);
      check($sformatf("vec%0d_pulses", i), 32'(p), 32'(vecs[i].pulses));
      check($sformatf("vec%0d_first", i),  32'(f), 32'(vecs[i].first));
      check($sformatf("vec%0d_last", i),   32'(l), 32'(vecs[i].last));
      check($sformatf("vec%0d_count", i),  32'(bus.prescale_count),
            32'(vecs[i].cycles % 1024));
    end

    // prescaler clear at counter = 40 with CS=011
    do_reset(8'h03);
    run_count(40, 0, p, f, l);
    check("psr_pre_count", 32'(bus.prescale_count), 32'd40);
    bus.PSR_clear = 1'b1;
    tick();
    check("psr_count_zero", 32'(bus.prescale_count), 32'd0);
    check("psr_done_pulse", 32'(bus.PSR_done),       32'd1);
    check("psr_cc_low",     32'(bus.countClock),     32'd0);
    bus.PSR_clear = 1'b0;
    tick();
    check("psr_done_single", 32'(bus.PSR_done), 32'd0);
    run_count(100, 0, p, f, l);
    // next pulse 64 edges after the clear edge; one of those edges already ticked
    check("psr_next_first",  32'(f), 32'd63);
    check("psr_next_pulses", 32'(p), 32'd1);

    // held clear request acknowledges once
    bus.PSR_clear = 1'b1;
    dn = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (bus.PSR_done === 1'b1) dn++;
    end
    bus.PSR_clear = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      if (bus.PSR_done === 1'b1) dn++;
    end
    check("psr_held_done_count", 32'(dn), 32'd1);
    check("psr_held_count",      32'(bus.prescale_count), 32'd2);

    // CS 100 -> 000 at counter = 200
    do_reset(8'h04);
    run_count(200, 0, p, f, l);
    check("cs_chg_count200", 32'(bus.prescale_count), 32'd200);
    bus.TCCR_data = 8'h00;
    run_count(400, 0, p, f, l);
    check("cs_chg_pulses", 32'(p), 32'd0);
    check("cs_chg_count",  32'(bus.prescale_count), 32'd600);

    // reset together with PSR_clear
    reset_n       = 1'b0;
    bus.PSR_clear = 1'b1;
    tick();
    check("rst_psr_count", 32'(bus.prescale_count), 32'd0);
    check("rst_psr_cc",    32'(bus.countClock),     32'd0);
    check("rst_psr_done",  32'(bus.PSR_done),       32'd0);
    tick();
    check("rst_psr_done2", 32'(bus.PSR_done), 32'd0);
    reset_n       = 1'b1;
    bus.PSR_clear = 1'b0;
    tick();
    check("rst_psr_done3",  32'(bus.PSR_done),       32'd0);
    check("rst_psr_count1", 32'(bus.prescale_count), 32'd1);

    // single T0 pulse, 10 cycles high
    for (int m = 0; m < 2; m++) begin
      int p_hi, f_hi, p_lo, f_lo;
      do_reset(m == 0 ? 8'h07 : 8'h06);
      run_count(5, 0, p, f, l);
      check($sformatf("t0_idle_%0d", m), 32'(p), 32'd0);
      bus.T0_pin = 1'b1;
      run_count(10, 0, p_hi, f_hi, l);
      bus.T0_pin = 1'b0;
      run_count(20, 0, p_lo, f_lo, l);
`ifdef TIMER0_EXT_CLK_EN
      check($sformatf("t0_hi_pulses_%0d", m), 32'(p_hi), m == 0 ? 32'd1 : 32'd0);
      check($sformatf("t0_hi_first_%0d", m),  32'(f_hi), m == 0 ? 32'd3 : 32'd0);
      check($sformatf("t0_lo_pulses_%0d", m), 32'(p_lo), m == 0 ? 32'd0 : 32'd1);
      check($sformatf("t0_lo_first_%0d", m),  32'(f_lo), m == 0 ? 32'd0 : 32'd3);
`else
      check($sformatf("t0_hi_pulses_%0d", m), 32'(p_hi), 32'd0);
      check($sformatf("t0_lo_pulses_%0d", m), 32'(p_lo), 32'd0);
`endif
    end

    @(negedge sysClock);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
